rf_wb_queue: RTL and testbench

Writeback staging queue that sits directly upstream of the 8x8b 1r1w register file. It buffers register write requests arriving on a valid/ready interface. It drains them in order, at most one per cycle, onto the register file write port (write_en/write_addr/write_data). It also provides a combinational lookup port so a reader can forward pending (not yet written) data. Writes to register zero are accepted and discarded, because register zero always reads zero.

---
 rtl/rf_wb_queue_pkg.sv | 12 +
 rtl/rf_wb_youngest_match.sv | 35 +++
 rtl/rf_wb_queue.sv | 97 +++++++++
 tb/tb_rf_wb_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_queue_pkg.sv
// Shared types and widths for the register-file writeback queue.
package rf_wb_queue_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_DATA_W = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } rf_wb_entry_t;

endpackage

// File: rtl/rf_wb_youngest_match.sv
// Combinational search for the youngest pending entry whose address matches the query.
module rf_wb_youngest_match
  import rf_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  rf_wb_entry_t          entries_i [DEPTH],
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PTR_W-1:0]      head_i,
  input  logic [CNT_W-1:0]      count_i,
  input  logic [REG_ADDR_W-1:0] query_i,
  output logic                  hit_o,
  output logic [REG_DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if ((CNT_W'(i) < count_i) && valid_i[idx] &&
          (query_i != '0) && (entries_i[idx].addr == query_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback staging FIFO in front of the register file, with a forwarding lookup port.
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       port_busy,
  output logic                       write_en,
  output logic [ADDR_W-1:0]          write_addr,
  output logic [DATA_W-1:0]          write_data,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic [DATA_W-1:0]          lookup_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  rf_wb_entry_t     entries_q [DEPTH];

  logic enq;
  logic deq;

  assign in_rdy   = (count_q != CNT_W'(DEPTH));
  assign write_en = (count_q != '0) && !port_busy;
  assign count    = count_q;

  // Register-zero writes complete the handshake but never occupy a slot.
  assign enq = in_val && in_rdy && (in_addr != '0);
  assign deq = write_en;

  assign write_addr = write_en ? entries_q[head_q].addr : '0;
  assign write_data = write_en ? entries_q[head_q].data : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      entries_q[tail_q] <= '{addr: in_addr, data: in_data};
    end
  end

  rf_wb_youngest_match #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W),
    .CNT_W(CNT_W)
  ) u_match (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .query_i   (lookup_addr),
    .hit_o     (lookup_hit),
    .data_o    (lookup_data)
  );

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed self-checking bench for rf_wb_queue.
module tb_rf_wb_queue;

  logic       clk;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [2:0] in_addr;
  logic [7:0] in_data;
  logic       port_busy;
  logic       write_en;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic [2:0] lookup_addr;
  logic       lookup_hit;
  logic [7:0] lookup_data;
  logic [2:0] count;

  int checks;
  int errors;

  rf_wb_queue #(
    .DEPTH(4),
    .ADDR_W(3),
    .DATA_W(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .port_busy   (port_busy),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_val = 1'b0; in_addr = '0; in_data = '0;
    port_busy = 1'b0; lookup_addr = 3'd3;
    #2;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy: got %0h expected 1", in_rdy); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL rst_write_en: got %0h expected 0", write_en); end
    checks++; if (write_addr !== 3'd0) begin errors++; $display("FAIL rst_write_addr: got %0h expected 0", write_addr); end
    checks++; if (write_data !== 8'd0) begin errors++; $display("FAIL rst_write_data: got %0h expected 0", write_data); end
    checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL rst_lookup_hit: got %0h expected 0", lookup_hit); end
    checks++; if (lookup_data !== 8'd0) begin errors++; $display("FAIL rst_lookup_data: got %0h expected 0", lookup_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0h expected 0", count); end
    next_cycle();
    @(negedge clk);
    reset = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL idle_in_rdy[%0d]: got %0h expected 1", i, in_rdy); end
      checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL idle_write_en[%0d]: got %0h expected 0", i, write_en); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL idle_count[%0d]: got %0h expected 0", i, count); end
      checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL idle_lookup_hit[%0d]: got %0h expected 0", i, lookup_hit); end
      next_cycle();
    end
  endtask

  task automatic test_single_write();
    port_busy = 1'b0; in_val = 1'b1; in_addr = 3'd3; in_data = 8'hab; lookup_addr = 3'd3;
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %0h expected 0", write_en); end
    checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL single_no_bypass_hit: got %0h expected 0", lookup_hit); end
    next_cycle();
    in_val = 1'b0;
    #1;
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL single_write_en: got %0h expected 1", write_en); end
    checks++; if (write_addr !== 3'd3) begin errors++; $display("FAIL single_write_addr: got %0h expected 3", write_addr); end
    checks++; if (write_data !== 8'hab) begin errors++; $display("FAIL single_write_data: got %0h expected ab", write_data); end
    checks++; if (lookup_hit !== 1'b1) begin errors++; $display("FAIL single_lookup_hit: got %0h expected 1", lookup_hit); end
    checks++; if (lookup_data !== 8'hab) begin errors++; $display("FAIL single_lookup_data: got %0h expected ab", lookup_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0h expected 1", count); end
    next_cycle();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL single_after_we: got %0h expected 0", write_en); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_after_count: got %0h expected 0", count); end
  endtask

  task automatic test_fill_stall();
    logic [2:0] exp_addr [6];
    logic [7:0] exp_data [6];
    logic       exp_we   [6];
    logic [2:0] exp_cnt  [6];
    exp_addr = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00};
    exp_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_cnt  = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    port_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_val = 1'b1; in_addr = 3'(i); in_data = 8'(i * 8'h11);
      #1;
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL fill_in_rdy[%0d]: got %0h expected 1", i, in_rdy); end
      next_cycle();
    end
    in_addr = 3'd5; in_data = 8'h55;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0h expected 4", count); end
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL full_in_rdy: got %0h expected 0", in_rdy); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL full_busy_we: got %0h expected 0", write_en); end
    next_cycle();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_hold_count: got %0h expected 4", count); end
    port_busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) in_val = 1'b0;
      #1;
      checks++; if (write_en !== exp_we[k]) begin errors++; $display("FAIL drain_we[%0d]: got %0h expected %0h", k, write_en, exp_we[k]); end
      checks++; if (write_addr !== exp_addr[k]) begin errors++; $display("FAIL drain_addr[%0d]: got %0h expected %0h", k, write_addr, exp_addr[k]); end
      checks++; if (write_data !== exp_data[k]) begin errors++; $display("FAIL drain_data[%0d]: got %0h expected %0h", k, write_data, exp_data[k]); end
      checks++; if (count !== exp_cnt[k]) begin errors++; $display("FAIL drain_count[%0d]: got %0h expected %0h", k, count, exp_cnt[k]); end
      if (k == 0) begin
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL drain_no_enq: got %0h expected 0", in_rdy); end
      end
      if (k == 1) begin
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL drain_reopen: got %0h expected 1", in_rdy); end
      end
      next_cycle();
    end
  endtask

  task automatic test_zero_reg();
    port_busy = 1'b0; in_val = 1'b1; in_addr = 3'd0; in_data = 8'hff; lookup_addr = 3'd0;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL zero_in_rdy: got %0h expected 1", in_rdy); end
    next_cycle();
    in_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL zero_count[%0d]: got %0h expected 0", i, count); end
      checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL zero_we[%0d]: got %0h expected 0", i, write_en); end
      checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL zero_lookup[%0d]: got %0h expected 0", i, lookup_hit); end
      next_cycle();
    end
  endtask

  task automatic test_forward_youngest();
    port_busy = 1'b1; lookup_addr = 3'd5;
    in_val = 1'b1; in_addr = 3'd5; in_data = 8'h01;
    next_cycle();
    in_data = 8'h02;
    next_cycle();
    in_val = 1'b0;
    #1;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL fwd_count: got %0h expected 2", count); end
    checks++; if (lookup_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit: got %0h expected 1", lookup_hit); end
    checks++; if (lookup_data !== 8'h02) begin errors++; $display("FAIL fwd_youngest: got %0h expected 02", lookup_data); end
    lookup_addr = 3'd6;
    #1;
    checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss_hit: got %0h expected 0", lookup_hit); end
    checks++; if (lookup_data !== 8'h00) begin errors++; $display("FAIL fwd_miss_data: got %0h expected 00", lookup_data); end
    lookup_addr = 3'd5; port_busy = 1'b0;
    #1;
    checks++; if (write_data !== 8'h01) begin errors++; $display("FAIL fwd_drain0: got %0h expected 01", write_data); end
    checks++; if (lookup_data !== 8'h02) begin errors++; $display("FAIL fwd_during_drain: got %0h expected 02", lookup_data); end
    next_cycle();
    checks++; if (lookup_hit !== 1'b1) begin errors++; $display("FAIL fwd_after1_hit: got %0h expected 1", lookup_hit); end
    checks++; if (lookup_data !== 8'h02) begin errors++; $display("FAIL fwd_after1_data: got %0h expected 02", lookup_data); end
    checks++; if (write_data !== 8'h02) begin errors++; $display("FAIL fwd_drain1: got %0h expected 02", write_data); end
    next_cycle();
    checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL fwd_after2_hit: got %0h expected 0", lookup_hit); end
    checks++; if (lookup_data !== 8'h00) begin errors++; $display("FAIL fwd_after2_data: got %0h expected 00", lookup_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fwd_after2_count: got %0h expected 0", count); end
  endtask

  task automatic test_reset_mid();
    port_busy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_val = 1'b1; in_addr = 3'(i); in_data = 8'(8'ha0 + i);
      next_cycle();
    end
    in_val = 1'b0; lookup_addr = 3'd2;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count: got %0h expected 3", count); end
    port_busy = 1'b0;
    #1;
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL mid_pre_we: got %0h expected 1", write_en); end
    reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0h expected 0", count); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL mid_we: got %0h expected 0", write_en); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL mid_in_rdy: got %0h expected 1", in_rdy); end
    checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL mid_lookup: got %0h expected 0", lookup_hit); end
    next_cycle();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL post_rst_we[%0d]: got %0h expected 0", i, write_en); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL post_rst_count[%0d]: got %0h expected 0", i, count); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_write();
    test_fill_stall();
    test_zero_reg();
    test_forward_youngest();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
